// File: rtl/regfile_sequencer.sv
// Multi-cycle register-to-register instruction sequencer: IDLE -> READ -> EXEC -> WRITE.
// Sole driver of the attached RegisterFile's ports; holds the zero and carry/borrow flags.
module regfile_sequencer #(
    parameter int SRCSIZE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [SRCSIZE-1:0] in_src1,
    input  logic [SRCSIZE-1:0] in_src2,
    input  logic [SRCSIZE-1:0] in_dst,
    input  logic [7:0]         in_imm,
    output logic               rf_write,
    output logic [SRCSIZE-1:0] rf_src1,
    output logic [SRCSIZE-1:0] rf_src2,
    output logic [SRCSIZE-1:0] rf_dst,
    output logic [7:0]         rf_data,
    input  logic [7:0]         rf_regA,
    input  logic [7:0]         rf_regB,
    output logic [7:0]         result,
    output logic               flag_z,
    output logic               flag_c,
    output logic               done,
    output logic               busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;

    logic [2:0]         r_op;
    logic [SRCSIZE-1:0] r_src1;
    logic [SRCSIZE-1:0] r_src2;
    logic [SRCSIZE-1:0] r_dst;
    logic [7:0]         r_imm;
    logic [7:0]         r_result;
    logic               r_z;
    logic               r_c;
    logic               r_done;

    logic [8:0]         w_sum;
    logic [8:0]         w_diff;
    logic [7:0]         w_alu;
    logic               w_alu_c;
    logic               w_upd;
    logic               w_upd_c;
    logic               w_writes;

    assign w_accept = in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Source addresses are loaded at the accept edge so the RF read is settled throughout READ and EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_NOP;
            r_src1 <= '0;
            r_src2 <= '0;
            r_dst  <= '0;
            r_imm  <= '0;
        end else if (w_accept) begin
            r_op   <= in_op;
            r_src1 <= in_src1;
            r_src2 <= in_src2;
            r_dst  <= in_dst;
            r_imm  <= in_imm;
        end
    end

    assign w_sum  = {1'b0, rf_regA} + {1'b0, rf_regB};
    assign w_diff = {1'b0, rf_regA} - {1'b0, rf_regB};

    always_comb begin
        w_alu    = 8'h00;
        w_alu_c  = 1'b0;
        w_upd    = 1'b1;
        w_upd_c  = 1'b0;
        w_writes = 1'b1;
        case (r_op)
            OP_ADD: begin
                w_alu   = w_sum[7:0];
                w_alu_c = w_sum[8];
                w_upd_c = 1'b1;
            end
            OP_SUB: begin
                w_alu   = w_diff[7:0];
                w_alu_c = w_diff[8];
                w_upd_c = 1'b1;
            end
            OP_AND: w_alu = rf_regA & rf_regB;
            OP_OR:  w_alu = rf_regA | rf_regB;
            OP_XOR: w_alu = rf_regA ^ rf_regB;
            OP_LDI: w_alu = r_imm;
            OP_CMP: begin
                w_alu    = w_diff[7:0];
                w_alu_c  = w_diff[8];
                w_upd_c  = 1'b1;
                w_writes = 1'b0;
            end
            default: begin
                w_upd    = 1'b0;
                w_writes = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 8'h00;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
        end else if (r_state == S_EXEC && w_upd) begin
            r_result <= w_alu;
            r_z      <= (w_alu == 8'h00);
            if (w_upd_c) r_c <= w_alu_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_WRITE);
        end
    end

    // Write strobe is decoded from the live state so an async reset mid-WRITE kills it at once.
    assign rf_write = (r_state == S_WRITE) && w_writes;
    assign rf_src1  = r_src1;
    assign rf_src2  = r_src2;
    assign rf_dst   = r_dst;
    assign rf_data  = r_result;
    assign result   = r_result;
    assign flag_z   = r_z;
    assign flag_c   = r_c;
    assign done     = r_done;
    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: behavioural RF, array-based ISA model,
// directed scenarios followed by random instruction streams.
module tb_regfile_sequencer;

    localparam int SRCSIZE = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [2:0]         in_op = 3'd0;
    logic [SRCSIZE-1:0] in_src1 = '0;
    logic [SRCSIZE-1:0] in_src2 = '0;
    logic [SRCSIZE-1:0] in_dst = '0;
    logic [7:0]         in_imm = 8'h00;
    logic               rf_write;
    logic [SRCSIZE-1:0] rf_src1;
    logic [SRCSIZE-1:0] rf_src2;
    logic [SRCSIZE-1:0] rf_dst;
    logic [7:0]         rf_data;
    logic [7:0]         rf_regA;
    logic [7:0]         rf_regB;
    logic [7:0]         result;
    logic               flag_z;
    logic               flag_c;
    logic               done;
    logic               busy;

    regfile_sequencer #(.SRCSIZE(SRCSIZE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_imm(in_imm),
        .rf_write(rf_write), .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_dst(rf_dst),
        .rf_data(rf_data), .rf_regA(rf_regA), .rf_regB(rf_regB),
        .result(result), .flag_z(flag_z), .flag_c(flag_c), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file environment: combinational reads, write on rising edge, not reset by rst.
    logic [7:0] rf_mem [4] = '{default: 8'h00};
    assign rf_regA = rf_mem[rf_src1];
    assign rf_regB = rf_mem[rf_src2];
    always @(posedge clk) if (rf_write) rf_mem[rf_dst] <= rf_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        int         dst;
        logic [7:0] dval;
        int         wr;
    } exp_t;

    exp_t q[$];

    // ISA reference model
    logic [7:0] m_reg [4] = '{default: 8'h00};
    logic [7:0] m_res = 8'h00;
    logic       m_z = 1'b0;
    logic       m_c = 1'b0;

    task automatic model(input int op, input int s1, input int s2, input int d, input int imm,
                         output exp_t e);
        int a, b, t;
        bit upd, wr;
        a = int'(m_reg[s1]);
        b = int'(m_reg[s2]);
        t = 0; upd = 1; wr = 1;
        case (op)
            0: begin t = a + b; m_c = (t > 255); end
            1: begin t = a - b; m_c = (a < b); end
            2: t = a & b;
            3: t = a | b;
            4: t = a ^ b;
            5: t = imm;
            6: begin t = a - b; m_c = (a < b); wr = 0; end
            default: begin upd = 0; wr = 0; end
        endcase
        if (upd) begin
            m_res = 8'(t & 255);
            m_z   = (m_res == 8'h00);
        end
        if (wr) m_reg[d] = m_res;
        e.res = m_res; e.z = m_z; e.c = m_c;
        e.dst = d; e.dval = m_reg[d]; e.wr = wr ? 1 : 0;
    endtask

    // Monitor: counts write strobes per instruction and scores each done pulse.
    int wr_cnt = 0;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt = 0;
        end else begin
            if (rf_write) wr_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_with_empty_scoreboard", {31'd0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", {24'd0, result}, {24'd0, e.res});
                    chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
                    chk("flag_c", {31'd0, flag_c}, {31'd0, e.c});
                    chk("rf_dst_value", {24'd0, rf_mem[e.dst]}, {24'd0, e.dval});
                    chk("rf_write_count", wr_cnt, e.wr);
                end
                wr_cnt = 0;
            end
        end
    end

    task automatic send(input int op, input int s1, input int s2, input int d, input int imm,
                        input bit hold, output int acc);
        exp_t e;
        int n;
        in_op = 3'(op); in_src1 = 2'(s1); in_src2 = 2'(s2); in_dst = 2'(d); in_imm = 8'(imm);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        model(op, s1, s2, d, imm, e);
        q.push_back(e);
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 100) begin @(negedge clk); n++; end
        chk("idle_timeout", q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        logic [7:0] snap [4];

        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
        chk("rst_rf_addr", {26'd0, rf_src1, rf_src2, rf_dst}, 32'd0);
        chk("rst_rf_data", {24'd0, rf_data}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LDI/LDI/ADD with cycle-accurate strobe checks
        send(5, 0, 0, 1, 8'h05, 0, a0);
        send(5, 0, 0, 2, 8'h03, 0, a1);
        send(0, 1, 2, 3, 0, 0, a2);
        chk("read_no_write", {31'd0, rf_write}, 32'd0);
        @(negedge clk);
        chk("exec_no_write", {31'd0, rf_write}, 32'd0);
        @(negedge clk);
        chk("write_strobe", {31'd0, rf_write}, 32'd1);
        chk("write_dst", {30'd0, rf_dst}, 32'd3);
        chk("write_data", {24'd0, rf_data}, 32'h08);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("idle_no_write", {31'd0, rf_write}, 32'd0);
        @(negedge clk);
        chk("done_single", {31'd0, done}, 32'd0);
        chk("spacing_0", a1 - a0, 4);
        chk("spacing_1", a2 - a1, 4);
        chk("add_r3", {24'd0, rf_mem[3]}, 32'h08);
        chk("add_flags", {30'd0, flag_z, flag_c}, 32'd0);

        // carry and borrow
        send(5, 0, 0, 0, 8'hF0, 0, a0);
        send(5, 0, 0, 1, 8'h20, 0, a0);
        send(0, 0, 1, 2, 0, 0, a0);
        wait_idle();
        chk("add_carry_val", {24'd0, rf_mem[2]}, 32'h10);
        chk("add_carry_c", {31'd0, flag_c}, 32'd1);
        send(1, 1, 0, 3, 0, 0, a0);
        wait_idle();
        chk("sub_borrow_val", {24'd0, rf_mem[3]}, 32'h30);
        chk("sub_borrow_c", {31'd0, flag_c}, 32'd1);

        // CMP same register, then NOP
        send(6, 1, 1, 1, 0, 0, a0);
        wait_idle();
        chk("cmp_flags", {30'd0, flag_z, flag_c}, 32'b10);
        chk("cmp_r1_kept", {24'd0, rf_mem[1]}, 32'h20);
        send(7, 0, 0, 0, 0, 0, a0);
        wait_idle();
        chk("nop_flags", {30'd0, flag_z, flag_c}, 32'b10);

        // in-place XOR, AND, OR
        send(5, 0, 0, 0, 8'h0F, 0, a0);
        send(4, 0, 0, 0, 0, 0, a0);
        wait_idle();
        chk("xor_inplace", {24'd0, rf_mem[0]}, 32'h00);
        chk("xor_z", {31'd0, flag_z}, 32'd1);
        send(5, 0, 0, 1, 8'h3C, 0, a0);
        send(5, 0, 0, 2, 8'hA5, 0, a0);
        send(2, 1, 2, 3, 0, 0, a0);
        send(3, 1, 2, 0, 0, 0, a0);
        wait_idle();
        chk("and_val", {24'd0, rf_mem[3]}, 32'h24);
        chk("or_val", {24'd0, rf_mem[0]}, 32'hBD);

        // reset during WRITE aborts the write
        send(5, 0, 0, 3, 8'h55, 0, a0);
        send(5, 0, 0, 1, 8'h01, 0, a0);
        send(5, 0, 0, 2, 8'h02, 0, a0);
        send(6, 1, 2, 0, 0, 0, a0);
        wait_idle();
        chk("pre_abort_c", {31'd0, flag_c}, 32'd1);
        snap = m_reg;
        send(0, 1, 2, 3, 0, 0, a0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_write_strobe", {31'd0, rf_write}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_rf_write", {31'd0, rf_write}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_flags", {30'd0, flag_z, flag_c}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        #1 rst = 1'b0;
        m_reg = snap;
        m_res = 8'h00; m_z = 1'b0; m_c = 1'b0;
        void'(q.pop_back());
        repeat (3) @(negedge clk);
        chk("abort_r3_kept", {24'd0, rf_mem[3]}, 32'h55);
        chk("abort_idle", {31'd0, in_ready}, 32'd1);

        // in_valid held high across back-to-back LDIs
        send(5, 0, 0, 1, 8'h11, 1, a0);
        send(5, 0, 0, 2, 8'h22, 1, a1);
        send(5, 0, 0, 3, 8'h33, 0, a2);
        wait_idle();
        chk("b2b_spacing_0", a1 - a0, 4);
        chk("b2b_spacing_1", a2 - a1, 4);
        chk("b2b_r1", {24'd0, rf_mem[1]}, 32'h11);
        chk("b2b_r2", {24'd0, rf_mem[2]}, 32'h22);
        chk("b2b_r3", {24'd0, rf_mem[3]}, 32'h33);

        // random streams
        for (int i = 0; i < 120; i++) begin
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                 bit'($urandom_range(0, 1)), a0);
        end
        in_valid = 1'b0;
        wait_idle();
        for (int r = 0; r < 4; r++) chk("final_reg", {24'd0, rf_mem[r]}, {24'd0, m_reg[r]});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
